// File: rtl/taxi_pkg.sv
// Shared types for the taxi trip meter: event code bits, meter states
// and the trip record handed to billing.
package taxi_pkg;

  localparam int EVT_INCR = 0;
  localparam int EVT_DECR = 1;
  localparam int EVT_ERR  = 2;

  localparam int REC_FARE_W = 16;
  localparam int REC_TICK_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    RIDE,
    CLOSE,
    FAULT
  } meter_state_t;

  // fare field is sized for the widest fare; narrower meters zero-extend
  typedef struct packed {
    logic [REC_FARE_W-1:0] fare;
    logic [REC_TICK_W-1:0] ticks;
  } trip_rec_t;

endpackage

// File: rtl/taxi_tick_prescaler.sv
// Meter tick prescaler: pulses tick once every TICK_DIV enabled cycles.
// clear restarts the count so each trip begins on a fresh tick period.
module taxi_tick_prescaler #(
  parameter int TICK_DIV = 100
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  localparam int CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = enable && !clear && (cnt == LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/taxi_trip_meter.sv
// Taxi trip meter: occupancy, trip FSM, running fare and a
// valid/ready trip record to billing; repeated errors latch FAULT.
module taxi_trip_meter
  import taxi_pkg::*;
#(
  parameter int MAX_SEATS     = 4,
  parameter int FARE_W        = 16,
  parameter int FARE_BASE     = 50,
  parameter int FARE_PER_TICK = 2,
  parameter int TICK_DIV      = 100,
  parameter int ERR_LIMIT     = 3,
  localparam int OCC_W        = $clog2(MAX_SEATS + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              evt_valid,
  input  logic [2:0]        evt_code,
  input  logic              clr_fault,
  output logic [OCC_W-1:0]  occupancy,
  output logic              trip_active,
  output logic [FARE_W-1:0] fare,
  output logic              fare_sat,
  output logic [1:0]        err_count,
  output logic              fault,
  output logic              evt_drop,
  output logic              rec_valid,
  input  logic              rec_ready,
  output logic [FARE_W-1:0] rec_fare,
  output logic [15:0]       rec_ticks
);

  localparam int ERR_W = $clog2(ERR_LIMIT + 1);

  meter_state_t      state, state_n;
  logic [OCC_W-1:0]  occ_n;
  logic [FARE_W-1:0] fare_n;
  logic              sat_n;
  logic [15:0]       ticks, ticks_n;
  logic [1:0]        err_n;
  logic [ERR_W-1:0]  err_tot, tot_n;
  logic              drop_n;
  trip_rec_t         rec, rec_n;
  logic [FARE_W:0]   sum;
  logic              tick, start, is_err;
  logic              inc, dec, bad;

  assign bad = evt_valid &
    (evt_code[EVT_ERR] |
     (evt_code[EVT_INCR] & evt_code[EVT_DECR]));
  assign inc = evt_valid & ~bad & evt_code[EVT_INCR];
  assign dec = evt_valid & ~bad & evt_code[EVT_DECR];

  taxi_tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_presc (
    .clk    (clk),
    .rst    (rst),
    .enable (state == RIDE),
    .clear  (start),
    .tick   (tick)
  );

  always_comb begin
    state_n = state;
    occ_n   = occupancy;
    fare_n  = fare;
    sat_n   = fare_sat;
    ticks_n = ticks;
    err_n   = err_count;
    tot_n   = err_tot;
    rec_n   = rec;
    start   = 1'b0;
    is_err  = 1'b0;
    sum     = {1'b0, fare} + (FARE_W+1)'(FARE_PER_TICK);
    drop_n  = evt_valid &&
      (state == CLOSE || state == FAULT);

    // tick arrives only in RIDE; an event on the same edge stacks on it
    if (tick) begin
      if (sum[FARE_W]) begin
        fare_n = '1;
        sat_n  = 1'b1;
      end else begin
        fare_n = sum[FARE_W-1:0];
      end
      if (ticks != 16'hFFFF) ticks_n = ticks + 16'd1;
    end

    unique case (state)
      IDLE: begin
        if (inc) begin
          start   = 1'b1;
          state_n = RIDE;
          occ_n   = OCC_W'(1);
          fare_n  = FARE_W'(FARE_BASE);
          sat_n   = 1'b0;
          ticks_n = '0;
          err_n   = '0;
          tot_n   = '0;
        end else if (dec || bad) begin
          is_err = 1'b1;
        end
      end
      RIDE: begin
        if (inc) begin
          if (occupancy == OCC_W'(MAX_SEATS)) is_err = 1'b1;
          else occ_n = occupancy + 1'b1;
        end else if (dec) begin
          occ_n = occupancy - 1'b1;
          if (occupancy == OCC_W'(1)) begin
            state_n     = CLOSE;
            rec_n.fare  = REC_FARE_W'(fare_n);
            rec_n.ticks = ticks_n;
          end
        end else if (bad) begin
          is_err = 1'b1;
        end
      end
      CLOSE: begin
        if (rec_ready) state_n = IDLE;
      end
      FAULT: begin
        if (clr_fault) begin
          state_n = IDLE;
          err_n   = '0;
          tot_n   = '0;
        end
      end
    endcase

    if (is_err) begin
      if (err_count != 2'd3) err_n = err_count + 2'd1;
      tot_n = err_tot + 1'b1;
      if (err_tot == ERR_W'(ERR_LIMIT - 1)) begin
        state_n = FAULT;
        occ_n   = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      occupancy <= '0;
      fare      <= '0;
      fare_sat  <= 1'b0;
      ticks     <= '0;
      err_count <= '0;
      err_tot   <= '0;
      evt_drop  <= 1'b0;
      rec       <= '0;
    end else begin
      state     <= state_n;
      occupancy <= occ_n;
      fare      <= fare_n;
      fare_sat  <= sat_n;
      ticks     <= ticks_n;
      err_count <= err_n;
      err_tot   <= tot_n;
      evt_drop  <= drop_n;
      rec       <= rec_n;
    end
  end

  assign trip_active = (state == RIDE);
  assign fault       = (state == FAULT);
  assign rec_valid   = (state == CLOSE);
  assign rec_fare    = rec.fare[FARE_W-1:0];
  assign rec_ticks   = rec.ticks;

endmodule

// File: tb/tb_taxi_trip_meter.sv
// Bench for taxi_trip_meter: directed trip scenarios plus random
// events against a trip-level reference model; second small-fare instance.
module tb_taxi_trip_meter;

  localparam int MAXS = 4;
  localparam int BASE = 50;
  localparam int PER  = 2;
  localparam int DIV  = 100;
  localparam int ELIM = 3;
  localparam int FMAX = 65535;

  localparam int M_IDLE  = 0;
  localparam int M_RIDE  = 1;
  localparam int M_CLOSE = 2;
  localparam int M_FAULT = 3;

  logic        clk = 0;
  logic        rst = 0;
  logic        evt_valid = 0;
  logic [2:0]  evt_code = 0;
  logic        clr_fault = 0;
  logic        rec_ready = 0;
  logic [2:0]  occupancy;
  logic        trip_active;
  logic [15:0] fare;
  logic        fare_sat;
  logic [1:0]  err_count;
  logic        fault;
  logic        evt_drop;
  logic        rec_valid;
  logic [15:0] rec_fare;
  logic [15:0] rec_ticks;

  logic        rst2 = 0;
  logic        v2 = 0;
  logic [2:0]  code2 = 0;
  logic        clr2 = 0;
  logic        rr2 = 0;
  logic [2:0]  occ2;
  logic        act2;
  logic [5:0]  fare2;
  logic        sat2;
  logic [1:0]  err2;
  logic        fault2;
  logic        drop2;
  logic        rv2;
  logic [5:0]  rf2;
  logic [15:0] rt2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  taxi_trip_meter dut (
    .clk(clk), .rst(rst), .evt_valid(evt_valid),
    .evt_code(evt_code), .clr_fault(clr_fault),
    .occupancy(occupancy), .trip_active(trip_active),
    .fare(fare), .fare_sat(fare_sat),
    .err_count(err_count), .fault(fault),
    .evt_drop(evt_drop), .rec_valid(rec_valid),
    .rec_ready(rec_ready), .rec_fare(rec_fare),
    .rec_ticks(rec_ticks)
  );

  taxi_trip_meter #(
    .FARE_W(6), .FARE_BASE(60), .TICK_DIV(2)
  ) dut2 (
    .clk(clk), .rst(rst2), .evt_valid(v2),
    .evt_code(code2), .clr_fault(clr2),
    .occupancy(occ2), .trip_active(act2),
    .fare(fare2), .fare_sat(sat2),
    .err_count(err2), .fault(fault2),
    .evt_drop(drop2), .rec_valid(rv2),
    .rec_ready(rr2), .rec_fare(rf2),
    .rec_ticks(rt2)
  );

  // trip-level reference model
  int m_mode, m_occ, m_rc, m_err, m_rf, m_rt;
  bit m_started, m_drop;

  function automatic int m_ticks();
    int t = m_rc / DIV;
    return (t > 65535) ? 65535 : t;
  endfunction

  function automatic int m_fare();
    int f;
    if (!m_started) return 0;
    f = BASE + PER * (m_rc / DIV);
    return (f > FMAX) ? FMAX : f;
  endfunction

  function automatic bit m_sat();
    return m_started && (BASE + PER * (m_rc / DIV) > FMAX);
  endfunction

  task automatic model_reset();
    m_mode = M_IDLE; m_occ = 0; m_rc = 0; m_err = 0;
    m_rf = 0; m_rt = 0; m_started = 0; m_drop = 0;
  endtask

  task automatic model_step(input bit v, input logic [2:0] c,
                            input bit rdy, input bit clr);
    bit bad, inc, dec, e;
    int nm;
    bad = v && (c[2] || c == 3'b011);
    inc = v && c == 3'b001;
    dec = v && c == 3'b010;
    e = 0;
    nm = m_mode;
    m_drop = v && (m_mode == M_CLOSE || m_mode == M_FAULT);
    case (m_mode)
      M_IDLE: begin
        if (inc) begin
          m_started = 1; m_occ = 1; m_rc = 0; m_err = 0;
          nm = M_RIDE;
        end else if (dec || bad) e = 1;
      end
      M_RIDE: begin
        m_rc++;
        if (inc) begin
          if (m_occ == MAXS) e = 1; else m_occ++;
        end else if (dec) begin
          m_occ--;
          if (m_occ == 0) begin
            nm = M_CLOSE; m_rf = m_fare(); m_rt = m_ticks();
          end
        end else if (bad) e = 1;
      end
      M_CLOSE: if (rdy) nm = M_IDLE;
      default: if (clr) begin nm = M_IDLE; m_err = 0; end
    endcase
    if (e) begin
      m_err++;
      if (m_err >= ELIM) begin nm = M_FAULT; m_occ = 0; end
    end
    m_mode = nm;
  endtask

  task automatic cycle(input bit v, input logic [2:0] c,
                       input bit rdy, input bit clr);
    evt_valid = v; evt_code = c; rec_ready = rdy; clr_fault = clr;
    model_step(v, c, rdy, clr);
    @(posedge clk); #1;
    evt_valid = 0; evt_code = 0; rec_ready = 0; clr_fault = 0;
  endtask

  task automatic cycle2(input bit v, input logic [2:0] c);
    v2 = v; code2 = c; rr2 = 1;
    @(posedge clk); #1;
    v2 = 0; code2 = 0;
  endtask

  task automatic test_reset();
    rst = 0; evt_valid = 0; clr_fault = 0; rec_ready = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({occupancy, trip_active, fare, fare_sat, err_count, fault,
         evt_drop, rec_valid, rec_fare, rec_ticks} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got occ=%0d fare=%0d rv=%0d exp all 0",
               occupancy, fare, rec_valid);
    end
    @(negedge clk) rst = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic_trip();
    cycle(1, 3'b001, 0, 0);
    checks++;
    if (occupancy !== 1 || trip_active !== 1) begin
      errors++;
      $display("FAIL basic_incr got occ=%0d act=%0d exp 1 1",
               occupancy, trip_active);
    end
    cycle(1, 3'b010, 1, 0);
    checks++;
    if (occupancy !== 0 || rec_valid !== 1 || rec_fare !== 16'd50 ||
        rec_ticks !== 16'd0) begin
      errors++;
      $display("FAIL basic_rec got occ=%0d rv=%0d rf=%0d rt=%0d exp 0 1 50 0",
               occupancy, rec_valid, rec_fare, rec_ticks);
    end
    cycle(0, 3'b000, 1, 0);
    checks++;
    if (rec_valid !== 0 || trip_active !== 0) begin
      errors++;
      $display("FAIL basic_idle got rv=%0d act=%0d exp 0 0",
               rec_valid, trip_active);
    end
  endtask

  task automatic test_ticks();
    cycle(1, 3'b001, 0, 0);
    repeat (350) cycle(0, 3'b000, 0, 0);
    checks++;
    if (fare !== 16'd56) begin
      errors++;
      $display("FAIL ticks_fare got %0d exp 56", fare);
    end
    cycle(1, 3'b010, 0, 0);
    checks++;
    if (rec_valid !== 1 || rec_fare !== 16'd56 || rec_ticks !== 16'd3) begin
      errors++;
      $display("FAIL ticks_rec got rv=%0d rf=%0d rt=%0d exp 1 56 3",
               rec_valid, rec_fare, rec_ticks);
    end
    cycle(0, 3'b000, 1, 0);
  endtask

  task automatic test_max_seats();
    repeat (5) cycle(1, 3'b001, 0, 0);
    checks++;
    if (occupancy !== 4 || err_count !== 1 || fault !== 0) begin
      errors++;
      $display("FAIL max_seats got occ=%0d err=%0d flt=%0d exp 4 1 0",
               occupancy, err_count, fault);
    end
    repeat (4) cycle(1, 3'b010, 0, 0);
    checks++;
    if (rec_valid !== 1 || occupancy !== 0 || rec_fare !== 16'd50) begin
      errors++;
      $display("FAIL max_rec got rv=%0d occ=%0d rf=%0d exp 1 0 50",
               rec_valid, occupancy, rec_fare);
    end
    cycle(0, 3'b000, 1, 0);
  endtask

  task automatic test_errors_fault();
    logic [2:0] codes [3];
    codes[0] = 3'b100; codes[1] = 3'b011; codes[2] = 3'b010;
    test_reset();
    for (int i = 0; i < 3; i++) begin
      cycle(1, codes[i], 0, 0);
      checks++;
      if (err_count !== 2'(i + 1) || fault !== (i == 2)) begin
        errors++;
        $display("FAIL err_step%0d got err=%0d flt=%0d exp %0d %0d",
                 i, err_count, fault, i + 1, i == 2);
      end
    end
    cycle(1, 3'b001, 0, 0);
    checks++;
    if (evt_drop !== 1 || fault !== 1 || occupancy !== 0) begin
      errors++;
      $display("FAIL fault_drop got drop=%0d flt=%0d occ=%0d exp 1 1 0",
               evt_drop, fault, occupancy);
    end
    cycle(0, 3'b000, 0, 1);
    checks++;
    if (fault !== 0 || err_count !== 0 || evt_drop !== 0) begin
      errors++;
      $display("FAIL fault_clr got flt=%0d err=%0d drop=%0d exp 0 0 0",
               fault, err_count, evt_drop);
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] rf0, rt0;
    cycle(1, 3'b001, 0, 0);
    repeat (120) cycle(0, 3'b000, 0, 0);
    cycle(1, 3'b010, 0, 0);
    rf0 = 16'(m_rf); rt0 = 16'(m_rt);
    checks++;
    if (rec_fare !== 16'd52 || rec_ticks !== 16'd1) begin
      errors++;
      $display("FAIL bp_rec got rf=%0d rt=%0d exp 52 1", rec_fare, rec_ticks);
    end
    for (int i = 0; i < 10; i++) begin
      cycle(1, 3'($urandom_range(0, 7)), 0, 0);
      checks++;
      if (rec_valid !== 1 || rec_fare !== rf0 || rec_ticks !== rt0 ||
          evt_drop !== 1) begin
        errors++;
        $display("FAIL bp_hold%0d got rv=%0d rf=%0d rt=%0d drop=%0d exp 1 %0d %0d 1",
                 i, rec_valid, rec_fare, rec_ticks, evt_drop, rf0, rt0);
      end
    end
    cycle(0, 3'b000, 1, 0);
    checks++;
    if (rec_valid !== 0 || evt_drop !== 0) begin
      errors++;
      $display("FAIL bp_release got rv=%0d drop=%0d exp 0 0",
               rec_valid, evt_drop);
    end
  endtask

  task automatic test_random();
    logic [2:0] c;
    bit v;
    for (int n = 0; n < 4000; n++) begin
      v = ($urandom_range(0, 11) == 0);
      case ($urandom_range(0, 9))
        0, 1, 2, 3: c = 3'b001;
        4, 5, 6, 7: c = 3'b010;
        8:          c = 3'b000;
        default:    c = 3'($urandom_range(3, 7));
      endcase
      cycle(v, c, $urandom_range(0, 1) == 1, $urandom_range(0, 7) == 0);
      checks++;
      if (occupancy !== 3'(m_occ) || trip_active !== (m_mode == M_RIDE) ||
          fault !== (m_mode == M_FAULT) ||
          rec_valid !== (m_mode == M_CLOSE) ||
          err_count !== 2'((m_err > 3) ? 3 : m_err) ||
          evt_drop !== m_drop) begin
        errors++;
        $display("FAIL rand_state@%0d got occ=%0d act=%0d flt=%0d rv=%0d err=%0d drop=%0d exp %0d mode=%0d err=%0d drop=%0d",
                 n, occupancy, trip_active, fault, rec_valid, err_count,
                 evt_drop, m_occ, m_mode, m_err, m_drop);
      end
      checks++;
      if (fare !== 16'(m_fare()) || fare_sat !== m_sat()) begin
        errors++;
        $display("FAIL rand_fare@%0d got %0d sat=%0d exp %0d sat=%0d",
                 n, fare, fare_sat, m_fare(), m_sat());
      end
      if (m_mode == M_CLOSE) begin
        checks++;
        if (rec_fare !== 16'(m_rf) || rec_ticks !== 16'(m_rt)) begin
          errors++;
          $display("FAIL rand_rec@%0d got rf=%0d rt=%0d exp %0d %0d",
                   n, rec_fare, rec_ticks, m_rf, m_rt);
        end
      end
    end
  endtask

  task automatic test_saturation();
    int f;
    bit seen;
    rst2 = 0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst2 = 1;
    @(posedge clk); #1;
    cycle2(1, 3'b001);
    checks++;
    if (fare2 !== 6'd60 || sat2 !== 0 || act2 !== 1) begin
      errors++;
      $display("FAIL sat_start got fare=%0d sat=%0d act=%0d exp 60 0 1",
               fare2, sat2, act2);
    end
    for (int k = 1; k <= 8; k++) begin
      cycle2(0, 3'b000);
      f = 60 + 2 * (k / 2);
      checks++;
      if (fare2 !== 6'((f > 63) ? 63 : f) || sat2 !== (f > 63)) begin
        errors++;
        $display("FAIL sat_k%0d got fare=%0d sat=%0d exp %0d %0d",
                 k, fare2, sat2, (f > 63) ? 63 : f, f > 63);
      end
    end
    cycle2(1, 3'b001);
    rst2 = 0;
    #2;
    checks++;
    if ({occ2, act2, fare2, sat2, err2, fault2, drop2, rv2, rf2, rt2}
        !== '0) begin
      errors++;
      $display("FAIL sat_reset got occ=%0d fare=%0d sat=%0d rv=%0d exp all 0",
               occ2, fare2, sat2, rv2);
    end
    @(negedge clk) rst2 = 1;
    @(posedge clk); #1;
    seen = 0;
    cycle2(1, 3'b010);
    for (int i = 0; i < 20; i++) begin
      if (rv2 === 1'b1) seen = 1;
      cycle2(0, 3'b000);
    end
    checks++;
    if (seen !== 0 || err2 !== 2'd1) begin
      errors++;
      $display("FAIL sat_no_record got rv_seen=%0d err=%0d exp 0 1",
               seen, err2);
    end
  endtask

  initial begin
    test_reset();
    test_basic_trip();
    test_ticks();
    test_max_seats();
    test_errors_fault();
    test_backpressure();
    test_random();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
